y86_regfile_dual_wr: RTL and testbench
======================================

Name: y86_regfile_dual_wr

Overview:
- Parametrised successor register file for the Y-86 decode/writeback path.
- Provides two combinational read ports (srcA/srcB) with same-cycle write-through bypass.
- Provides two synchronous write ports (dstE/valE, dstM/valM) with defined collision priority.
- Includes a register-dump sequencer that streams the whole file out one entry per cycle for bench and debug; this replaces per-writeback printing.

Parameters:
- DATA_W, 64, register data width in bits.
- NREGS, 16, number of architectural registers; must be a power of 2.
- ADDR_W, 4, register index width; equals log2(NREGS).
- RNONE, 15, "no register" index; writes to it are dropped, reads of it return 0.
- RSP_IDX, 4, stack-pointer register index.
- RSP_INIT, 128, value loaded into RSP_IDX at reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- srcA  in  ADDR_W  read port A index.
- srcB  in  ADDR_W  read port B index.
- valA  out  DATA_W  read data A (combinational).
- valB  out  DATA_W  read data B (combinational).
- dstE  in  ADDR_W  E write index; RNONE means no write.
- valE  in  DATA_W  E write data.
- dstM  in  ADDR_W  M write index; RNONE means no write.
- valM  in  DATA_W  M write data.
- wr_en  in  1  global write enable; 0 stalls both write ports.
- dump_req  in  1  one-cycle pulse that starts a full-file dump.
- dump_busy  out  1  high while the dump sequencer is active.
- dump_valid  out  1  dump_idx/dump_data are valid this cycle.
- dump_idx  out  ADDR_W  index being dumped.
- dump_data  out  DATA_W  value of register dump_idx.
- dump_done  out  1  one-cycle pulse after the last entry.

Behaviour:
- Reset (async, immediate on rst high):
  - All registers clear to 0, except register RSP_IDX, which loads RSP_INIT.
  - dump_busy, dump_valid and dump_done go to 0; dump_idx and dump_data go to 0.
  - The FSM enters IDLE.
- Writes:
  - On posedge clk with wr_en=1: reg[dstE] <= valE if dstE != RNONE; reg[dstM] <= valM if dstM != RNONE.
  - If dstE == dstM != RNONE, M wins, so reg gets valM. This matches Y-86 popq %rsp semantics.
  - wr_en=0 leaves the file unchanged.
- Reads (combinational):
  - valX = 0 if srcX == RNONE.
  - Otherwise, if wr_en and dstM == srcX, valX = valM.
  - Otherwise, if wr_en and dstE == srcX, valX = valE.
  - Otherwise, valX = reg[srcX].
  - Result: a value written this cycle is visible on the read ports in the same cycle (bypass). M has priority over E, consistent with the write rule.
- Dump FSM (states IDLE, DUMP, DONE):
  - IDLE: on a clk edge with dump_req=1 -> DUMP, counter <= 0, dump_busy <= 1.
  - DUMP: each cycle dump_valid=1, dump_idx=counter, dump_data=reg[counter] as registered at that edge. The data therefore reflects all writes committed at earlier edges, not the same-edge write.
  - DUMP: the counter increments each cycle. After index NREGS-1 -> DONE.
  - Total: exactly NREGS consecutive valid cycles, indices 0..NREGS-1 in order with no gaps.
  - DONE: dump_done=1 and dump_valid=0 for one cycle -> IDLE, dump_busy <= 0.
  - dump_req while busy (DUMP or DONE) is ignored and not queued.
  - Writes continue normally during a dump. A write to an index not yet dumped appears in the dump.
  - dump_idx and dump_data hold their last values when dump_valid=0.
- Reset mid-dump: the FSM returns to IDLE immediately, no dump_done is produced, and the file is reinitialised.
- Latency: read 0 cycles; write visible in the file at the next edge (same cycle via bypass); dump is NREGS+1 cycles from the req edge to dump_done.
- No arithmetic inside the block; widths are exact, with no truncation or extension.

Test Plan:
- Reset then dump_req -> 16 valid beats, with reg4=128 and all others 0, then dump_done on the 17th cycle.
- wr_en=1, dstE=2, valE=0x55, srcA=2 in the same cycle -> valA=0x55 via bypass; next cycle, with dstE=RNONE, valA=0x55 from the file.
- dstE=dstM=4, valE=0x100, valM=0x200 -> valA (srcA=4) = 0x200 in that cycle, and reg4=0x200 afterwards.
- wr_en=0, dstE=1, valE=0xFF -> reg1 is unchanged at 0. Separately, dstE=RNONE with srcA=RNONE -> valA=0 and no register changes.
- Start a dump, then at dump_idx=3 write reg7=0x77 and assert a second dump_req -> beat 7 shows 0x77, the second request is ignored, and exactly one dump_done is produced.
- Assert rst at dump_idx=5 -> dump_busy and dump_valid drop asynchronously, no dump_done, reg4 reads 128 and reg2 reads 0.

Source files
------------

// File: rtl/y86_regfile_dual_wr.sv
// y86_regfile_dual_wr
//   Y-86 register file with two combinational read ports (srcA/srcB) that
//   bypass same-cycle writes, and two synchronous write ports (dstE/valE,
//   dstM/valM). When both write ports target the same register, M wins, which
//   gives popq %rsp its architectural result. A dump sequencer streams every
//   register out, one per cycle, for bench and debug visibility.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   srcA, srcB -> valA, valB  combinational reads (RNONE reads as 0)
//   dstE/valE, dstM/valM      write ports (RNONE drops the write)
//   wr_en                     global write enable (0 stalls both write ports)
//   dump_req                  pulse that starts a full-file dump
//   dump_busy                 sequencer active (DUMP or DONE)
//   dump_valid                dump_idx/dump_data carry a beat this cycle
//   dump_idx, dump_data       index and value of the current beat
//   dump_done                 one-cycle pulse after the last beat
module y86_regfile_dual_wr #(
  parameter int unsigned           DATA_W   = 64,
  parameter int unsigned           NREGS    = 16,
  parameter int unsigned           ADDR_W   = 4,
  parameter logic [ADDR_W-1:0]     RNONE    = ADDR_W'(15),
  parameter logic [ADDR_W-1:0]     RSP_IDX  = ADDR_W'(4),
  parameter logic [DATA_W-1:0]     RSP_INIT = DATA_W'(128)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              wr_en,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DUMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  // Read with bypass: M is checked before E so the read port agrees with the
  // value the file will hold after a colliding write.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] src);
    logic [DATA_W-1:0] v;
    if (src == RNONE)
      v = '0;
    else if (wr_en && (dstM == src))
      v = valM;
    else if (wr_en && (dstE == src))
      v = valE;
    else
      v = regs_q[src];
    return v;
  endfunction

  always_comb begin
    valA = rd_port(srcA);
    valB = rd_port(srcB);
  end

  // M is applied after E so it overrides on a collision.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      if (dstE != RNONE) regs_d[dstE] = valE;
      if (dstM != RNONE) regs_d[dstM] = valM;
    end
  end

  // Each beat's data is captured from regs_q (pre-edge contents) at the edge
  // that enters the beat, so it reflects writes committed at earlier edges.
  // The counter holds in DONE/IDLE so dump_idx keeps its last value.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dump_data_d = dump_data_q;
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d     = ST_DUMP;
          cnt_d       = '0;
          dump_data_d = regs_q[0];
        end
      end
      ST_DUMP: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          dump_data_d = regs_q[cnt_q + 1'b1];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q          <= '{default: '0};
      regs_q[RSP_IDX] <= RSP_INIT;
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      dump_data_q     <= '0;
    end else begin
      regs_q      <= regs_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dump_data_q <= dump_data_d;
    end
  end

  always_comb begin
    dump_busy  = (state_q != ST_IDLE);
    dump_valid = (state_q == ST_DUMP);
    dump_done  = (state_q == ST_DONE);
    dump_idx   = cnt_q;
    dump_data  = dump_data_q;
  end

endmodule

// File: tb/tb_y86_regfile_dual_wr.sv
// tb_y86_regfile_dual_wr
//   Directed bench for y86_regfile_dual_wr. Dump beats are predicted into a
//   queue when a dump is requested; a monitor on the falling edge pops and
//   compares each presented beat and counts dump_done pulses. Read-port
//   results are compared directly against hand-computed values.
module tb_y86_regfile_dual_wr;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam logic [AW-1:0] RN = 4'd15;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] srcA, srcB, dstE, dstM;
  logic [DW-1:0] valA, valB, valE, valM;
  logic          wr_en, dump_req;
  logic          dump_busy, dump_valid, dump_done;
  logic [AW-1:0] dump_idx;
  logic [DW-1:0] dump_data;

  always #5 clk = ~clk;

  y86_regfile_dual_wr #(
    .DATA_W(64), .NREGS(16), .ADDR_W(4),
    .RNONE(4'd15), .RSP_IDX(4'd4), .RSP_INIT(64'd128)
  ) dut (
    .clk(clk), .rst(rst),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .wr_en(wr_en), .dump_req(dump_req),
    .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model [16];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  int            done_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = '0;
    model[4] = 64'd128;
  endtask

  task automatic push_beats(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.idx  = 4'(i);
      b.data = model[i];
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; dstE = RN; dstM = RN; valE = '0; valM = '0; dump_req = 1'b0;
  endtask

  // Counts falling edges until dump_done, bounded at 40.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dump_done && cyc < 40);
  endtask

  // Monitor: pops one expected beat per valid cycle.
  always @(negedge clk) begin
    if (dump_valid && dump_done) chk("valid_and_done_together", 1, 0);
    if (dump_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_idx", 64'(dump_idx), 64'hFFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_idx", 64'(dump_idx), 64'(b.idx));
        chk($sformatf("beat_data[%0d]", b.idx), dump_data, b.data);
      end
    end
    if (dump_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    srcA = 4'd4; srcB = 4'd0;
    idle_inputs();
    model_reset();
    tick(); tick();
    chk("rst_busy", 64'(dump_busy), 0);
    chk("rst_valid", 64'(dump_valid), 0);
    chk("rst_done", 64'(dump_done), 0);
    chk("rst_idx", 64'(dump_idx), 0);
    chk("rst_data", dump_data, 0);
    chk("rst_rsp", valA, 64'd128);
    chk("rst_r0", valB, 0);
    rst = 1'b0;
    tick();

    // Dump after reset: 16 beats then dump_done on the 17th cycle.
    push_beats(16);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_done(cyc);
    chk("dump1_latency", 64'(cyc), 17);
    chk("dump1_busy_in_done", 64'(dump_busy), 1);
    tick();
    chk("dump1_busy_after", 64'(dump_busy), 0);
    chk("dump1_idx_hold", 64'(dump_idx), 15);
    chk("dump1_done_count", 64'(done_cnt), 1);
    chk("dump1_queue_empty", 64'(exp_q.size()), 0);

    // E-port write with same-cycle bypass, then from the file.
    wr_en = 1'b1; dstE = 4'd2; valE = 64'h55; srcA = 4'd2; srcB = 4'd2;
    #2;
    chk("bypass_e_A", valA, 64'h55);
    chk("bypass_e_B", valB, 64'h55);
    tick();
    model[2] = 64'h55;
    dstE = RN;
    #2;
    chk("file_r2", valA, 64'h55);

    // Collision on reg4: M wins in bypass and in the file.
    dstE = 4'd4; valE = 64'h100; dstM = 4'd4; valM = 64'h200; srcA = 4'd4;
    #2;
    chk("collide_bypass", valA, 64'h200);
    tick();
    model[4] = 64'h200;
    dstE = RN; dstM = RN;
    #2;
    chk("collide_file", valA, 64'h200);

    // Independent E and M writes to different registers.
    dstE = 4'd3; valE = 64'h33; dstM = 4'd5; valM = 64'h5A; srcA = 4'd3; srcB = 4'd5;
    #2;
    chk("bypass_e_r3", valA, 64'h33);
    chk("bypass_m_r5", valB, 64'h5A);
    tick();
    model[3] = 64'h33; model[5] = 64'h5A;

    // wr_en=0 stalls the write and disables the bypass.
    wr_en = 1'b0; dstE = 4'd1; valE = 64'hFF; dstM = RN; srcA = 4'd1; srcB = 4'd3;
    #2;
    chk("stall_no_bypass", valA, 0);
    tick();
    idle_inputs();
    #2;
    chk("stall_r1_unchanged", valA, 0);
    chk("file_r3", valB, 64'h33);

    // RNONE write is dropped and RNONE reads as zero.
    wr_en = 1'b1; dstE = RN; valE = 64'hDEAD; dstM = RN; valM = 64'hBEEF; srcA = RN;
    #2;
    chk("rnone_read", valA, 0);
    tick();
    idle_inputs();

    // Dump with a write to reg7 and a second request at idx 3.
    model[7] = 64'h77;
    push_beats(16);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(dump_valid && dump_idx == 4'd3) && cyc < 40);
    chk("dump2_reach_idx3", 64'(dump_idx), 3);
    wr_en = 1'b1; dstE = 4'd7; valE = 64'h77; dump_req = 1'b1;
    tick();
    idle_inputs();
    wait_done(cyc);
    chk("dump2_done_seen", 64'(dump_done), 1);
    repeat (25) tick();
    chk("dump2_done_count", 64'(done_cnt), 2);
    chk("dump2_busy_after", 64'(dump_busy), 0);
    chk("dump2_queue_empty", 64'(exp_q.size()), 0);

    // Reset in the middle of a dump, at idx 5.
    push_beats(6);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(dump_valid && dump_idx == 4'd5) && cyc < 40);
    chk("dump3_reach_idx5", 64'(dump_idx), 5);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(dump_busy), 0);
    chk("midrst_valid", 64'(dump_valid), 0);
    model_reset();
    srcA = 4'd4; srcB = 4'd2;
    tick();
    rst = 1'b0;
    #2;
    chk("midrst_rsp", valA, 64'd128);
    chk("midrst_r2", valB, 0);
    repeat (20) tick();
    chk("midrst_no_done", 64'(done_cnt), 2);
    chk("midrst_queue_empty", 64'(exp_q.size()), 0);

    // Post-reset dump confirms the whole file was reinitialised.
    push_beats(16);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_done(cyc);
    chk("dump4_latency", 64'(cyc), 17);
    tick();
    chk("dump4_queue_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
